// File: rtl/psram_rx_deserializer.sv
// Receive-side PSRAM deserializer: discards the command/address bits of each
// frame, packs the remaining SO bits MSB-first into bytes and queues them in a FIFO.
module psram_rx_deserializer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             ce_n,
    input  logic             in,
    input  logic [7:0]       skip_bits,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_done,
    output logic             frame_partial,
    output logic [CNT_W-1:0] frame_bytes,
    output logic             overflow,
    input  logic             clear_ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE} state_t;

    state_t           state_q, state_d;
    logic             ce_q;
    logic [7:0]       skip_rem_q, skip_rem_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_partial_q, frame_partial_d;
    logic [CNT_W-1:0] frame_bytes_q, frame_bytes_d;
    logic             overflow_q, overflow_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    logic       frame_start, frame_end;
    logic       push, push_ok, pop, full;
    logic [7:0] push_byte;

    // Ends are only honoured inside a frame we actually saw start.
    assign frame_start = !ce_n && ce_q;
    assign frame_end   = ce_n && !ce_q && (state_q != IDLE);
    assign push_byte   = {shift_q[6:0], in};

    always_comb begin
        state_d         = state_q;
        skip_rem_d      = skip_rem_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        frame_done_d    = 1'b0;
        frame_partial_d = frame_partial_q;
        frame_bytes_d   = frame_bytes_q;
        push            = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    byte_cnt_d = '0;
                    if (skip_bits == 8'd0) begin
                        shift_d   = push_byte;
                        bit_cnt_d = 3'd1;
                        state_d   = CAPTURE;
                    end else begin
                        bit_cnt_d  = 3'd0;
                        skip_rem_d = skip_bits - 8'd1;
                        state_d    = (skip_bits == 8'd1) ? CAPTURE : SKIP;
                    end
                end
            end
            SKIP: begin
                if (!ce_n) begin
                    skip_rem_d = skip_rem_q - 8'd1;
                    if (skip_rem_q == 8'd1) state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!ce_n) begin
                    shift_d = push_byte;
                    if (bit_cnt_q == 3'd7) begin
                        push      = 1'b1;
                        bit_cnt_d = 3'd0;
                        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (frame_end) begin
            state_d         = IDLE;
            frame_done_d    = 1'b1;
            frame_partial_d = (state_q == SKIP) || (bit_cnt_q != 3'd0);
            frame_bytes_d   = byte_cnt_q;
            bit_cnt_d       = 3'd0;
        end
    end

    // The output register lags the pointers by a cycle, so it never shows an unwritten slot.
    always_comb begin
        pop        = rx_valid_q && rx_ready;
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok    = push && (!full || pop);
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        rx_valid_d = (wr_ptr_q != rd_ptr_d);
        rx_data_d  = rx_valid_d ? mem_q[rd_ptr_d[AW-1:0]] : rx_data_q;
        overflow_d = (push && !push_ok) ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
        mem_d      = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_byte;
    end

    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

    // ce_q resets low so a frame already in progress at reset release is not seen as a start.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q         <= IDLE;
            ce_q            <= 1'b0;
            skip_rem_q      <= 8'd0;
            shift_q         <= 8'd0;
            bit_cnt_q       <= 3'd0;
            byte_cnt_q      <= '0;
            frame_done_q    <= 1'b0;
            frame_partial_q <= 1'b0;
            frame_bytes_q   <= '0;
            overflow_q      <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            rx_data_q       <= 8'd0;
            rx_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            ce_q            <= ce_n;
            skip_rem_q      <= skip_rem_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            frame_done_q    <= frame_done_d;
            frame_partial_q <= frame_partial_d;
            frame_bytes_q   <= frame_bytes_d;
            overflow_q      <= overflow_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign frame_done    = frame_done_q;
    assign frame_partial = frame_partial_q;
    assign frame_bytes   = frame_bytes_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_psram_rx_deserializer.sv
// Scoreboard bench for psram_rx_deserializer: expected bytes and frame results are
// queued as frames are driven and checked as the DUT delivers them.
module tb_psram_rx_deserializer;
    localparam int CNT_W = 16;

    logic             sys_clk = 1'b0;
    logic             sys_reset = 1'b1;
    logic             ce_n = 1'b1;
    logic             in = 1'b0;
    logic [7:0]       skip_bits = 8'd0;
    logic             rx_ready = 1'b0;
    logic             clear_ovf = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_done;
    logic             frame_partial;
    logic [CNT_W-1:0] frame_bytes;
    logic             overflow;

    psram_rx_deserializer #(.DEPTH(8), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .ce_n(ce_n), .in(in),
        .skip_bits(skip_bits), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_done(frame_done), .frame_partial(frame_partial),
        .frame_bytes(frame_bytes), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    int vectorCount = 0;
    int failCount = 0;
    int frameDoneCount = 0;
    logic [7:0]  expBytes[$];
    int          expFrameBytes[$];
    logic        expPartial[$];
    logic [511:0] frameBits;
    int          frameLen;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearFrame();
        frameBits = '0;
        frameLen = 0;
    endtask

    task automatic addBits(input logic [7:0] b, input int w);
        frameBits = (frameBits << w) | {504'd0, b};
        frameLen += w;
    endtask

    task automatic expectFrame(input int nbytes, input logic partial);
        expFrameBytes.push_back(nbytes);
        expPartial.push_back(partial);
    endtask

    // Drives the built frame first-bit-first, then one ce_n=1 cycle; rx_ready rises at bit readyAt.
    task automatic applyStimulus(input logic [7:0] skip, input int readyAt);
        @(posedge sys_clk); #1;
        ce_n = 1'b0;
        skip_bits = skip;
        in = frameBits[frameLen-1];
        for (int i = 1; i < frameLen; i++) begin
            @(posedge sys_clk); #1;
            in = frameBits[frameLen-1-i];
            skip_bits = 8'($urandom);
            if (i == readyAt) rx_ready = 1'b1;
        end
        @(posedge sys_clk); #1;
        ce_n = 1'b1;
        in = 1'($urandom);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (!sys_reset) begin
            if (rx_valid && rx_ready) begin
                if (expBytes.size() == 0) checkOutput("rx_byte_expected", 32'(expBytes.size()), 32'd1);
                else checkOutput("rx_data", 32'(rx_data), 32'(expBytes.pop_front()));
            end
            if (frame_done) begin
                frameDoneCount++;
                if (expFrameBytes.size() == 0) begin
                    checkOutput("frame_done_expected", 32'(expFrameBytes.size()), 32'd1);
                end else begin
                    checkOutput("frame_bytes", 32'(frame_bytes), 32'(expFrameBytes.pop_front()));
                    checkOutput("frame_partial", 32'(frame_partial), 32'(expPartial.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int doneBefore;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_frame_partial", 32'(frame_partial), 32'd0);
        checkOutput("reset_frame_bytes", 32'(frame_bytes), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        @(posedge sys_clk); #1;
        sys_reset = 1'b0;
        waitCycles(2);

        // Command/address phase skipped, two data bytes
        rx_ready = 1'b1;
        clearFrame();
        addBits(8'h03, 8); addBits(8'h70, 8); addBits(8'hF0, 8); addBits(8'hFE, 8);
        addBits(8'h66, 8); addBits(8'hA5, 8);
        expBytes.push_back(8'h66); expBytes.push_back(8'hA5);
        expectFrame(2, 1'b0);
        applyStimulus(8'd32, -1);
        waitCycles(4);

        // No skip, one byte plus a dangling nibble
        clearFrame();
        addBits(8'hC3, 8); addBits(8'h0F, 4);
        expBytes.push_back(8'hC3);
        expectFrame(1, 1'b1);
        applyStimulus(8'd0, -1);
        waitCycles(4);

        // Overflow: ten bytes into an 8-deep FIFO with no consumer
        rx_ready = 1'b0;
        clearFrame();
        for (int b = 0; b < 10; b++) addBits(8'(b), 8);
        for (int b = 0; b < 8; b++) expBytes.push_back(8'(b));
        expectFrame(10, 1'b0);
        applyStimulus(8'd0, -1);
        waitCycles(3);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            checkOutput("head_held_valid", 32'(rx_valid), 32'd1);
            checkOutput("head_held_data", 32'(rx_data), 32'h00);
        end
        @(posedge sys_clk); #1;
        rx_ready = 1'b1;
        waitCycles(12);
        checkOutput("drained_valid", 32'(rx_valid), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        waitCycles(1);
        clear_ovf = 1'b0;
        @(negedge sys_clk);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a pop in the same cycle the ninth byte completes
        rx_ready = 1'b0;
        clearFrame();
        for (int b = 0; b < 9; b++) begin
            addBits(8'h20 + 8'(b), 8);
            expBytes.push_back(8'h20 + 8'(b));
        end
        expectFrame(9, 1'b0);
        applyStimulus(8'd0, 71);
        waitCycles(14);
        checkOutput("full_pop_no_ovf", 32'(overflow), 32'd0);

        // Reset in the middle of a frame with ce_n still low
        doneBefore = frameDoneCount;
        @(posedge sys_clk); #1;
        ce_n = 1'b0;
        skip_bits = 8'd32;
        in = 1'($urandom);
        for (int i = 1; i < 20; i++) begin
            @(posedge sys_clk); #1;
            in = 1'($urandom);
        end
        sys_reset = 1'b1;
        @(posedge sys_clk); #1;
        sys_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk); #1;
            in = 1'($urandom);
        end
        ce_n = 1'b1;
        waitCycles(4);
        checkOutput("abort_no_frame_done", 32'(frameDoneCount - doneBefore), 32'd0);
        checkOutput("abort_no_byte", 32'(rx_valid), 32'd0);

        clearFrame();
        addBits(8'($urandom), 8); addBits(8'h5A, 8);
        expBytes.push_back(8'h5A);
        expectFrame(1, 1'b0);
        applyStimulus(8'd8, -1);
        waitCycles(4);

        // Back-to-back frames separated by a single ce_n=1 cycle
        doneBefore = frameDoneCount;
        clearFrame();
        addBits(8'h11, 8);
        expBytes.push_back(8'h11);
        expectFrame(1, 1'b0);
        applyStimulus(8'd0, -1);
        clearFrame();
        addBits(8'h22, 8);
        expBytes.push_back(8'h22);
        expectFrame(1, 1'b0);
        applyStimulus(8'd0, -1);
        waitCycles(4);
        checkOutput("b2b_frame_done_count", 32'(frameDoneCount - doneBefore), 32'd2);

        checkOutput("bytes_outstanding", 32'(expBytes.size()), 32'd0);
        checkOutput("frames_outstanding", 32'(expFrameBytes.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end
endmodule

// File: doc/psram_rx_deserializer.md
# psram_rx_deserializer

Receive-side companion to the serial PSRAM command driver: it watches the driver's chip-enable, samples the PSRAM serial output pin once per PSRAM clock, and discards the command/address bit phase. It then assembles the remaining data bits MSB-first into bytes and delivers them through a small FIFO with a valid/ready handshake to the system logic downstream.

## Interface
Parameters:
- DEPTH, 8, FIFO depth in bytes; power of two, 2..64.
- CNT_W, 16, width of the per-frame byte counter.

Ports:
- sys_clk  input  1  system clock; the PSRAM clock is gated from this clock while ce_n is low.
- sys_reset  input  1  synchronous, active-high reset.
- ce_n  input  1  PSRAM chip enable, as driven by the command driver (0 = frame active).
- in  input  1  PSRAM serial data out (SO).
- skip_bits  input  8  number of leading frame bits to discard; latched at frame start.
- rx_data  output  8  head-of-FIFO byte.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_done  output  1  one-cycle pulse after each frame ends.
- frame_partial  output  1  valid with frame_done; 1 if the frame ended mid-byte.
- frame_bytes  output  CNT_W  bytes captured in the last completed frame; held until the next frame_done.
- overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.
- clear_ovf  input  1  clears overflow.

## Operation
- ce_q is ce_n registered; a frame starts on the first cycle with ce_n=0 and ce_q=1, and ends on the first cycle with ce_n=1 and ce_q=0.
- State machine IDLE / SKIP / CAPTURE:
  - IDLE -> SKIP at frame start when skip_bits != 0. IDLE -> CAPTURE at frame start when skip_bits == 0. The frame-start cycle's bit is bit index 0.
  - SKIP: count the discarded bits; go to CAPTURE after skip_bits bits have been discarded. The next bit is data bit 7 of byte 0.
  - CAPTURE: shift `in` into an 8-bit shift register MSB-first. On the 8th bit, push the byte to the FIFO, increment the frame byte counter, and clear the bit counter.
  - Any state -> IDLE at frame end, which pulses frame_done.
- A bit is sampled on every sys_clk rising edge where ce_n=0. ce_n=1 cycles sample nothing.
- Frame end during SKIP or with 1..7 bits pending in CAPTURE: the pending bits are discarded and frame_partial=1.
- Frame end with 0 bits pending in CAPTURE: frame_partial=0.
- frame_bytes is loaded from the frame byte counter at frame end. The counter clears at the next frame start and saturates at all-ones.
- FIFO: a push when full drops the byte and sets overflow. The exception is a simultaneous pop in the same cycle: then the push succeeds and overflow is not set. A pop when empty is ignored.
- Pointers are log2(DEPTH)+1 bits and wrap; an occupancy counter is not required.
- clear_ovf and a same-cycle overflow event: the set wins.
- skip_bits is ignored except in the frame-start cycle.

## Timing
- Reset values: rx_valid=0, rx_data=0, frame_done=0, frame_partial=0, frame_bytes=0, overflow=0. The state machine goes to IDLE, FIFO pointers clear, and the shift and bit counters clear.
- Reset mid-frame aborts the frame without a frame_done pulse. If ce_n is still low when reset releases, the block waits in IDLE for the next ce_n falling transition; the remainder of that frame is ignored.
- Latency: the 8th data bit is sampled at edge N; the byte is pushed at edge N; rx_valid=1 and rx_data are valid after edge N+1 when the FIFO was empty. This is 1 cycle.
- frame_done is asserted the cycle after the end-detect edge, for exactly 1 cycle.
- Back-to-back frames separated by a single ce_n=1 cycle are handled. frame_done for frame k may coincide with the start of frame k+1.
- rx_data is registered from the FIFO head and must not change while rx_valid && !rx_ready.
- Throughput: 1 bit per sys_clk; a byte every 8 cycles, always below the FIFO drain rate of 1 byte per cycle.

## Test plan
- skip_bits=32, ce_n low for 48 cycles, `in` serializes 0x03,0x70,0xF0,0xFE then 0x66,0xA5 -> rx bytes 0x66, 0xA5; frame_done pulse; frame_bytes=2; frame_partial=0.
- skip_bits=0, 12 bits 0xC3 then 0xF (4 bits), rx_ready=1 -> one byte 0xC3; frame_partial=1; frame_bytes=1.
- DEPTH=8, rx_ready=0, frame of 10 bytes 0x00..0x09 -> FIFO holds 0x00..0x07; overflow=1 after byte 0x08. Drain -> exactly 0x00..0x07 in order. clear_ovf -> overflow=0.
- FIFO full with rx_ready=1 asserted in the same cycle a byte completes -> no overflow; the byte order is preserved.
- sys_reset asserted after 20 bits of a frame, held 1 cycle, ce_n still low -> no frame_done and no byte from the aborted frame. The next full frame with skip_bits=8, data 0x5A after the skip -> 0x5A.
- Two frames of 1 byte each (0x11, 0x22) separated by one ce_n=1 cycle -> two frame_done pulses, frame_bytes=1 each, bytes 0x11, 0x22.
